store_align_unit: RTL
=====================

// Module: store_align_unit
// PURPOSE
//  Parametrised big-endian store aligner for the memory stage. Accepts one
//  store request per handshake (right-justified data, byte address, size),
//  drives byte lanes and byte enables onto a DW-wide bus, and splits accesses
//  crossing a bus-word boundary into two beats. Registered output with
//  valid/ready backpressure; sits between the LSU issue and the data-cache
//  write port.
// PARAMETERS
//  DW             32  bus data width in bits; 32 or 64; NB = DW/8 byte lanes
//  AW             32  address width in bits
//  ALLOW_MISALIGN 1   1: split boundary-crossing stores into 2 beats; 0: reject them
// PORTS
//  CLK        in   1     clock; all state updates on its rising edge
//  RESET      in   1     synchronous, active-high reset
//  REQ_VALID  in   1     store request valid
//  REQ_READY  out  1     unit can accept a request this cycle
//  REQ_ADDR   in   AW    byte address of first (most significant) byte
//  REQ_DATA   in   DW    store value, right-justified in REQ_DATA[8*S-1:0]
//  REQ_SIZE   in   2     log2 of byte count S: 0=byte 1=half 2=word 3=dword
//  BUS_VALID  out  1     bus beat valid
//  BUS_READY  in   1     bus accepts beat
//  BUS_ADDR   out  AW    bus-word-aligned address (low log2(NB) bits = 0)
//  BUS_BE     out  NB    byte enables; BUS_BE[NB-1] = lane 0 (lowest address)
//  BUS_DATA   out  DW    lane L on BUS_DATA[DW-1-8L -: 8]; disabled lanes = 0
//  BUS_LAST   out  1     final beat of the current request
//  ERR        out  1     one-cycle pulse: request rejected, no beat issued
// BEHAVIOUR
//  - Reset (sync): state IDLE; BUS_VALID, BUS_BE, BUS_DATA, BUS_ADDR, BUS_LAST, ERR = 0.
//    REQ_READY = 0 while RESET is high. RESET overrides any beat in flight,
//    including an unaccepted beat 1; that beat is dropped.
//  - States: IDLE, BEAT0, BEAT1.
//    IDLE->BEAT0 on accept of a legal request; BEAT0->BEAT1 on BUS_READY if not LAST;
//    BEATx->IDLE on BUS_READY with LAST, unless a new request is accepted that cycle.
//  - REQ_READY = !RESET && (IDLE || (BUS_VALID && BUS_LAST && BUS_READY)).
//    Back-to-back single-beat stores sustain 1 request/cycle.
//  - Latency: beat 0 is presented the cycle after acceptance; beat 1 the cycle
//    after beat 0 handshakes.
//  - Mapping: o = REQ_ADDR mod NB; value byte k (k=0 is REQ_DATA[8S-1 -: 8]) goes to
//    address REQ_ADDR+k.
//    If o+S <= NB: one beat, lanes o..o+S-1, BUS_ADDR = REQ_ADDR with low bits
//    cleared, BUS_LAST = 1.
//  - If o+S > NB and ALLOW_MISALIGN=1: beat 0 carries lanes o..NB-1 (bytes 0..NB-o-1),
//    BUS_LAST = 0. Beat 1 is at BUS_ADDR+NB and carries lanes 0..o+S-NB-1 (the
//    remaining bytes), BUS_LAST = 1. Address wraps modulo 2^AW.
//  - If o+S > NB and ALLOW_MISALIGN=0, or S > NB (e.g. REQ_SIZE=3 with DW=32):
//    request is accepted (consumed) and ERR = 1 the next cycle. No BUS_VALID is
//    raised; state stays IDLE.
//  - While BUS_VALID && !BUS_READY: all BUS_* outputs hold stable.
//  - REQ_* inputs are sampled only on accept; they may change freely afterwards.
// TESTING (DW=32 unless noted)
//  1. word 0x100, data 0xAABBCCDD -> 1 beat: ADDR 0x100, BE 1111, DATA AABBCCDD, LAST 1.
//  2. byte 0x103, data 0xEE -> BE 0001, DATA 000000EE; half 0x101, data 0x1234 ->
//     BE 0110, DATA 00123400.
//  3. word 0x102, data 0x11223344 -> beat0 ADDR 0x100 BE 0011 DATA 00001122 LAST 0;
//     beat1 ADDR 0x104 BE 1100 DATA 33440000 LAST 1.
//  4. BUS_READY low 3 cycles on test-3 beat0 -> outputs stable, REQ_READY 0;
//     5 back-to-back bytes with BUS_READY=1 -> 5 beats in 5 consecutive cycles.
//  5. ALLOW_MISALIGN=0, word 0x102 -> ERR pulse 1 cycle, BUS_VALID stays 0;
//     DW=32 with REQ_SIZE=3 -> ERR.
//  6. RESET during test-3 beat1 (BUS_READY=0) -> BUS_VALID 0 next cycle, IDLE;
//     DW=64 dword 0x7FC -> beats BE 00001111 / 11110000.

Source files
------------

// File: rtl/store_align_unit_if.sv
// store_align_unit_if
//   Bundles the request handshake and the aligned bus-beat handshake of the
//   big-endian store aligner.
//   Request side : REQ_VALID/REQ_READY, REQ_ADDR (byte address), REQ_DATA
//                  (right-justified value), REQ_SIZE (log2 byte count).
//   Bus side     : BUS_VALID/BUS_READY, BUS_ADDR (bus-word aligned), BUS_BE
//                  (BUS_BE[NB-1] = lane 0), BUS_DATA (lane 0 in the top byte),
//                  BUS_LAST (final beat of a request).
//   ERR          : one-cycle pulse when a request is consumed but rejected.
//   Modports: slave = the aligner, master = the LSU/bus side driving it.
interface store_align_unit_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    localparam int NB = DW / 8;

    logic          REQ_VALID;
    logic          REQ_READY;
    logic [AW-1:0] REQ_ADDR;
    logic [DW-1:0] REQ_DATA;
    logic [1:0]    REQ_SIZE;
    logic          BUS_VALID;
    logic          BUS_READY;
    logic [AW-1:0] BUS_ADDR;
    logic [NB-1:0] BUS_BE;
    logic [DW-1:0] BUS_DATA;
    logic          BUS_LAST;
    logic          ERR;

    modport slave (
        input  REQ_VALID, REQ_ADDR, REQ_DATA, REQ_SIZE, BUS_READY,
        output REQ_READY, BUS_VALID, BUS_ADDR, BUS_BE, BUS_DATA, BUS_LAST, ERR
    );

    modport master (
        output REQ_VALID, REQ_ADDR, REQ_DATA, REQ_SIZE, BUS_READY,
        input  REQ_READY, BUS_VALID, BUS_ADDR, BUS_BE, BUS_DATA, BUS_LAST, ERR
    );
endinterface

// File: rtl/store_align_unit.sv
// store_align_unit
//   Big-endian store aligner between LSU issue and the data-cache write port.
//   Takes one right-justified store per request handshake, places its bytes
//   on the byte lanes of a DW-wide bus and, when the access crosses a bus-word
//   boundary, splits it into two beats (or rejects it when ALLOW_MISALIGN=0).
//   Ports:
//     CLK   - clock, rising edge
//     RESET - synchronous, active-high
//     bus   - store_align_unit_if.slave: request handshake in, registered
//             bus beat out (valid/ready backpressure), ERR pulse out.
module store_align_unit #(
    parameter int DW             = 32,
    parameter int AW             = 32,
    parameter int ALLOW_MISALIGN = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    store_align_unit_if.slave  bus
);
    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t        state_q, state_d;
    logic          bus_valid_q, bus_valid_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [NB-1:0] bus_be_q, bus_be_d;
    logic [DW-1:0] bus_data_q, bus_data_d;
    logic          bus_last_q, bus_last_d;
    logic          err_q, err_d;
    // Second beat is computed at accept time and parked here until beat 0 goes.
    logic [AW-1:0] b1_addr_q, b1_addr_d;
    logic [NB-1:0] b1_be_q, b1_be_d;
    logic [DW-1:0] b1_data_q, b1_data_d;

    logic [2*NB-1:0] win_be;
    logic [2*DW-1:0] win_data;
    logic            split;
    logic            illegal;
    logic            req_ready;
    logic            accept;
    logic [AW-1:0]   base_addr;

    // Two consecutive bus words form a 2*NB-lane window; lane L of the window
    // is address base+L. Value byte k lands on lane off+k, so beat 0 is the
    // upper half of the window and beat 1 the lower half.
    always_comb begin : window
        int off;
        int nbytes;
        int k;
        win_be   = '0;
        win_data = '0;
        off      = int'(bus.REQ_ADDR[OW-1:0]);
        nbytes   = 1 << bus.REQ_SIZE;
        k        = 0;
        for (int l = 0; l < 2 * NB; l++) begin
            k = l - off;
            if (k >= 0 && k < nbytes && nbytes <= NB) begin
                win_be[2*NB-1-l]           = 1'b1;
                win_data[2*DW-1-8*l -: 8] = bus.REQ_DATA[8*(nbytes-1-k) +: 8];
            end
        end
        split   = (off + nbytes > NB);
        illegal = (nbytes > NB) || (split && (ALLOW_MISALIGN == 0));
    end

    assign base_addr = {bus.REQ_ADDR[AW-1:OW], {OW{1'b0}}};

    // A new request may enter when idle or when the final beat leaves this cycle.
    assign req_ready = !RESET &&
                       ((state_q == IDLE) || (bus_valid_q && bus_last_q && bus.BUS_READY));
    assign accept    = bus.REQ_VALID && req_ready;

    always_comb begin
        state_d     = state_q;
        bus_valid_d = bus_valid_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_data_d  = bus_data_q;
        bus_last_d  = bus_last_q;
        err_d       = 1'b0;
        b1_addr_d   = b1_addr_q;
        b1_be_d     = b1_be_q;
        b1_data_d   = b1_data_q;

        if (bus_valid_q && bus.BUS_READY) begin
            if (!bus_last_q) begin
                state_d    = BEAT1;
                bus_addr_d = b1_addr_q;
                bus_be_d   = b1_be_q;
                bus_data_d = b1_data_q;
                bus_last_d = 1'b1;
            end else begin
                state_d     = IDLE;
                bus_valid_d = 1'b0;
            end
        end

        if (accept) begin
            if (illegal) begin
                // Consumed but dropped: no beat, stay (or return to) IDLE.
                err_d = 1'b1;
            end else begin
                state_d     = BEAT0;
                bus_valid_d = 1'b1;
                bus_addr_d  = base_addr;
                bus_be_d    = win_be[2*NB-1 -: NB];
                bus_data_d  = win_data[2*DW-1 -: DW];
                bus_last_d  = !split;
                b1_addr_d   = base_addr + AW'(NB);
                b1_be_d     = win_be[NB-1:0];
                b1_data_d   = win_data[DW-1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_data_q  <= '0;
            bus_last_q  <= 1'b0;
            err_q       <= 1'b0;
            b1_addr_q   <= '0;
            b1_be_q     <= '0;
            b1_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            bus_valid_q <= bus_valid_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_data_q  <= bus_data_d;
            bus_last_q  <= bus_last_d;
            err_q       <= err_d;
            b1_addr_q   <= b1_addr_d;
            b1_be_q     <= b1_be_d;
            b1_data_q   <= b1_data_d;
        end
    end

    assign bus.REQ_READY = req_ready;
    assign bus.BUS_VALID = bus_valid_q;
    assign bus.BUS_ADDR  = bus_addr_q;
    assign bus.BUS_BE    = bus_be_q;
    assign bus.BUS_DATA  = bus_data_q;
    assign bus.BUS_LAST  = bus_last_q;
    assign bus.ERR       = err_q;
endmodule
